// File: rtl/multi_issue_instr_queue.sv
// Multi-lane instruction queue: up to FETCH_WIDTH pushes and ISSUE_WIDTH show-ahead pops per cycle.
// Optional statistics outputs (stall_cycles, high_water) are enabled by defining QUEUE_STATS_EN.
module multi_issue_instr_queue #(
  parameter int DEPTH       = 16,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int ENTRY_W     = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 push_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]     push_count,
  input  logic [FETCH_WIDTH*ENTRY_W-1:0]       push_data,
  output logic                                 push_ready,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     pop_count,
  output logic [ISSUE_WIDTH*ENTRY_W-1:0]       issue_data,
  output logic [ISSUE_WIDTH-1:0]               issue_valid,
  output logic [$clog2(DEPTH+1)-1:0]           count,
  output logic                                 empty,
`ifdef QUEUE_STATS_EN
  output logic [31:0]                          stall_cycles,
  output logic [$clog2(DEPTH+1)-1:0]           high_water,
`endif
  output logic                                 full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(FETCH_WIDTH+1);

  logic [AW-1:0]      rd_ptr_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;
  logic [CW-1:0]      pushed;
  logic [CW-1:0]      pop_ext;
  logic [CW-1:0]      eff_pop;
  logic               push_fire;
  logic [AW-1:0]      wr_addr [FETCH_WIDTH];
  logic [ENTRY_W-1:0] mem [DEPTH];

  // Readiness looks only at registered occupancy so it never depends on the consumer.
  assign push_ready = count_reg <= CW'(DEPTH - FETCH_WIDTH);
  assign push_fire  = push_valid && push_ready && !flush;
  assign pop_ext    = CW'(pop_count);

  always_comb begin
    pushed = '0;
    if (push_fire)
      pushed = (push_count > PW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : CW'(push_count);
    eff_pop    = (pop_ext > count_reg) ? count_reg : pop_ext;
    count_next = flush ? '0 : (count_reg + pushed - eff_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_reg + AW'(eff_pop);
      wr_ptr_reg <= wr_ptr_reg + AW'(pushed);
      count_reg  <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_wr_addr
      assign wr_addr[gi] = wr_ptr_reg + AW'(gi);
    end
  endgenerate

  // Storage carries no reset; validity is tracked entirely by count_reg.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (CW'(i) < pushed)
        mem[wr_addr[i]] <= push_data[i*ENTRY_W +: ENTRY_W];
    end
  end

  generate
    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_issue
      assign issue_data[gi*ENTRY_W +: ENTRY_W] = mem[rd_ptr_reg + AW'(gi)];
      assign issue_valid[gi]                   = count_reg > CW'(gi);
    end
  endgenerate

  assign count = count_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

`ifdef QUEUE_STATS_EN
  logic [31:0]   stall_reg;
  logic [CW-1:0] high_water_reg;

  // Statistics survive flush; only the hard reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_reg      <= '0;
      high_water_reg <= '0;
    end else begin
      if (push_valid && !push_ready && !flush && (stall_reg != 32'hFFFF_FFFF))
        stall_reg <= stall_reg + 32'd1;
      if (count_next > high_water_reg)
        high_water_reg <= count_next;
    end
  end

  assign stall_cycles = stall_reg;
  assign high_water   = high_water_reg;
`endif

endmodule

// File: doc/multi_issue_instr_queue.md
Name: multi_issue_instr_queue

Overview:
Parametrised successor to the fixed dual-entry fetch FIFO and execute buffer pair. Sits between the instruction cache controller and decode. Accepts up to FETCH_WIDTH {pc, instr} entries per cycle and presents up to ISSUE_WIDTH oldest entries per cycle to decode/issue in show-ahead form. Supports a variable consume count and a single-cycle flush on a taken jump.

Parameters:
DEPTH, 16, number of entries; power of 2, at least 2*max(FETCH_WIDTH, ISSUE_WIDTH).
FETCH_WIDTH, 2, maximum entries written per cycle.
ISSUE_WIDTH, 2, maximum entries presented and consumed per cycle.
ENTRY_W, 64, entry width; the format is {instr[31:0], pc[31:0]}.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous flush of all entries (taken jump or redirect).
push_valid  in  1  push request.
push_count  in  $clog2(FETCH_WIDTH+1)  number of valid push lanes, 1..FETCH_WIDTH; lane 0 is oldest.
push_data  in  FETCH_WIDTH*ENTRY_W  push lanes; lane i is bits [i*ENTRY_W +: ENTRY_W].
push_ready  out  1  high when free slots >= FETCH_WIDTH.
pop_count  in  $clog2(ISSUE_WIDTH+1)  number of entries consumed this cycle by issue.
issue_data  out  ISSUE_WIDTH*ENTRY_W  oldest entries; lane 0 is the head.
issue_valid  out  ISSUE_WIDTH  thermometer mask; bit i high when count > i.
count  out  $clog2(DEPTH+1)  current occupancy.
empty  out  1  count == 0.
full  out  1  count == DEPTH.

Behaviour:
- State: registers rd_ptr and wr_ptr, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH; a separate count register; storage array mem[DEPTH]. The storage array is not reset.
- Reset (asynchronous): rd_ptr=0, wr_ptr=0, count=0. As a result push_ready=1, issue_valid=0, empty=1, full=0. issue_data contents are don't-care while invalid.
- push_ready is derived from the registered count only, as (DEPTH-count) >= FETCH_WIDTH. It is not credited with a same-cycle pop.
- Push fires when push_valid && push_ready && !flush.
  - Lanes 0..push_count-1 are written to mem[(wr_ptr+i) mod DEPTH].
  - wr_ptr advances by push_count.
  - push_count = 0 with push_valid = 1 is treated as no push.
- Pop:
  - Effective pop is eff_pop = min(pop_count, count).
  - rd_ptr advances by eff_pop.
  - Popping more entries than are valid is clamped, never underflows, and leaves state consistent.
- Simultaneous push and pop: count_next = count + pushed - eff_pop. Both pointers update in the same cycle.
- issue_data is combinational from mem at (rd_ptr+i) mod DEPTH, giving zero-latency show-ahead.
- Push-to-issue latency is one cycle: an entry written at edge N is visible on issue_data after edge N.
- Wrap-around: a multi-lane push or pop straddling index DEPTH-1 to 0 is handled per lane with modulo addressing. Order is strictly preserved.
- Flush:
  - At the next edge, rd_ptr=wr_ptr=0 and count=0.
  - A push and pop in the same cycle are discarded.
  - issue_valid is 0 the cycle after the flush edge.
- Overflow is impossible by construction. count never exceeds DEPTH.
- full and empty are combinational from count.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Optional Feature:
QUEUE_STATS_EN.
- Defined: adds output stall_cycles[31:0], which increments each cycle with push_valid && !push_ready && !flush and saturates at 32'hFFFF_FFFF.
- Defined: adds output high_water[$clog2(DEPTH+1)-1:0], which holds the maximum count_next reached.
- Both statistics are cleared by rst_n only; flush does not clear them.
- Undefined: neither port nor its logic exists, and behaviour is otherwise identical.

Test Plan:
1. Reset, then push_count=2 for lanes {pc 0x0, pc 0x4}, pop_count=0 → next cycle count=2, issue_valid=2'b11, lane0 pc=0x0, lane1 pc=0x4.
2. Fill to 14 with DEPTH=16 and FETCH_WIDTH=2 → push_ready=1. Push 2 more → count=16, full=1, push_ready=0. A push attempt is ignored and count stays 16.
3. Pointers near 15: push 2 entries (pc 0x100, 0x104) from wr_ptr=15 → stored at indices 15 and 0. Two pops return 0x100 then 0x104 in order.
4. count=1, pop_count=2 → eff_pop=1, count=0, empty=1, rd_ptr advanced by 1 only.
5. count=5, flush with simultaneous push_count=2 and pop_count=2 → next cycle count=0, issue_valid=0, push_ready=1.
6. With QUEUE_STATS_EN: hold push_valid for 3 cycles while full → stall_cycles=3. high_water=16 persists after flush and is cleared only by rst_n=0.
